axilite_mmio_bridge: RTL and testbench
======================================

Name: axilite_mmio_bridge

Overview:
- Parametrised local-MMIO-to-AXI4-Lite master bridge; next generation of the fixed 32-bit MMIO shim.
- Sits between the MMIO decode logic and AXI-Lite slave register banks (action/infrastructure config space).
- Adds configurable address/data width, byte strobes, and independent AW/W handshake tracking.
- Adds an explicit single-outstanding FSM with busy/drop reporting, full AXI response code return, and an optional transaction timeout.

Parameters:
- ADDR_W, 32, address width of the local bus and AXI AW/AR.
- DATA_W, 32, data width; legal values 32 or 64; STRB_W = DATA_W/8 is derived.
- TIMEOUT_CYC, 1024, cycles in any non-IDLE state before abort; used only with the optional feature; must be >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- lcl_wr  in  1  write request pulse
- lcl_rd  in  1  read request pulse
- lcl_addr  in  ADDR_W  request address
- lcl_wdata  in  DATA_W  write data
- lcl_wstrb  in  STRB_W  write byte enables
- lcl_busy  out  1  transaction in flight
- lcl_drop  out  1  pulse: request ignored
- lcl_ack  out  1  pulse: write complete
- lcl_dv  out  1  pulse: read data valid
- lcl_rdata  out  DATA_W  read data
- lcl_resp  out  2  AXI response code of the completed transaction
- lcl_timeout  out  1  pulse: transaction aborted
- m_axi_awvalid/awready/awaddr[ADDR_W]/awprot[3]: standard AXI write address channel
- m_axi_wvalid/wready/wdata[DATA_W]/wstrb[STRB_W]: standard AXI write data channel
- m_axi_bvalid/bready/bresp[2]: standard AXI write response channel
- m_axi_arvalid/arready/araddr[ADDR_W]/arprot[3]: standard AXI read address channel
- m_axi_rvalid/rready/rdata[DATA_W]/rresp[2]: standard AXI read data channel

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; awprot and arprot are constant 3'b000.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA.
- lcl_busy = (state != IDLE).
- Request acceptance:
  - Requests are accepted only in IDLE.
  - If lcl_wr and lcl_rd are asserted together, the write wins, the read is ignored, and lcl_drop pulses the next cycle.
  - Any lcl_wr or lcl_rd while busy is ignored and pulses lcl_drop for 1 cycle.
- Write path:
  - On lcl_wr in IDLE (cycle 0): capture addr, wdata, wstrb; in cycle 1, awvalid=wvalid=1 and state = WR_REQ.
  - awvalid deasserts the cycle after the aw handshake; wvalid likewise after the w handshake, independently; either may complete first or both may complete together.
  - When both handshakes are done, go to WR_RESP with bready=1.
  - On bvalid&&bready: bready=0, state returns to IDLE; next cycle lcl_ack=1 and lcl_resp=bresp.
- Read path:
  - On lcl_rd in IDLE: capture addr; in cycle 1, arvalid=1 and state = RD_REQ.
  - After the ar handshake: arvalid=0, rready=1, state = RD_DATA.
  - On rvalid&&rready: rready=0, state returns to IDLE; next cycle lcl_dv=1, lcl_rdata=rdata, lcl_resp=rresp.
  - lcl_rdata holds its value until the next read completes.
- Minimum latency with a zero-wait slave: request to ack/dv = 4 cycles.
- Valid signals never drop before their handshake except on timeout or reset. Address and data stay stable while valid is high.
- A new request is accepted in the same cycle lcl_ack/lcl_dv pulses, because the FSM is already in IDLE.
- Reset mid-transaction: all valids and readies drop immediately (async) and the in-flight transaction is lost; no ack/dv is issued.

Optional Feature:
- Macro: AXILITE_MMIO_BRIDGE_TIMEOUT_EN.
- With the macro:
  - A counter clears on entering any non-IDLE state and increments each cycle in that state.
  - At TIMEOUT_CYC: drop all valids and readies, return to IDLE.
  - Next cycle: pulse lcl_timeout, plus lcl_ack (write) or lcl_dv (read) with lcl_resp=2'b11 and lcl_rdata all-ones.
  - A late B/R beat arriving after timeout is not accepted (ready=0).
- Without the macro: no counter; the bridge waits indefinitely; lcl_timeout is tied 0.

Decomposition:
- Package axilite_mmio_bridge_pkg contains:
  - FSM state enum.
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - TIMEOUT_RDATA fill pattern.
- Sub-module axilite_mmio_bridge_timer: the clearable saturating cycle counter with expiry pulse, instantiated only under the macro.

Test Plan:
- Write addr=0x10, data=0xA5A5_0001, wstrb=4'hF, zero-wait slave -> aw/w valid in cycle 1, bready in cycle 2, lcl_ack in cycle 4, lcl_resp=00.
- Slave asserts wready 3 cycles before awready -> wvalid drops first, awvalid holds until its handshake, exactly one B accepted, lcl_ack=1 once.
- Read addr=0x20, slave returns rdata=0xDEAD_0042, rresp=2'b10 after 5 wait cycles -> lcl_dv=1 once, lcl_rdata=0xDEAD_0042, lcl_resp=10.
- lcl_wr and lcl_rd in the same cycle, then lcl_rd while busy -> only the write issued; lcl_drop pulses twice; no arvalid.
- With the macro and TIMEOUT_CYC=16, slave never asserts bvalid -> 16 cycles in WR_RESP, bready drops, lcl_timeout=lcl_ack=1, lcl_resp=11; the next read completes normally.
- rst_n low while arvalid=1 -> arvalid=0 immediately, busy=0, no lcl_dv after reset release.

Source files
------------

// File: rtl/axilite_mmio_bridge_pkg.sv
// Shared types and constants for the local-MMIO to AXI4-Lite bridge.
package axilite_mmio_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Wide enough for the largest legal DATA_W; users slice it down.
   localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/axilite_mmio_bridge_timer.sv
// Clearable saturating cycle counter; expired pulses on the TIMEOUT_CYC-th enabled cycle.
module axilite_mmio_bridge_timer #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_eff;

   // clr marks the first cycle of a state, which counts as cycle zero.
   assign cnt_eff = clr ? '0 : cnt;
   assign expired = en && (cnt_eff == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (en)
         cnt <= (cnt_eff == CW'(TIMEOUT_CYC)) ? cnt_eff : cnt_eff + 1'b1;
   end

endmodule

// File: rtl/axilite_mmio_bridge.sv
// Single-outstanding local-MMIO to AXI4-Lite master bridge.
// Optional transaction timeout enabled by defining AXILITE_MMIO_BRIDGE_TIMEOUT_EN.
module axilite_mmio_bridge
   import axilite_mmio_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lcl_wr,
   input  logic                  lcl_rd,
   input  logic [ADDR_W-1:0]     lcl_addr,
   input  logic [DATA_W-1:0]     lcl_wdata,
   input  logic [DATA_W/8-1:0]   lcl_wstrb,
   output logic                  lcl_busy,
   output logic                  lcl_drop,
   output logic                  lcl_ack,
   output logic                  lcl_dv,
   output logic [DATA_W-1:0]     lcl_rdata,
   output logic [1:0]            lcl_resp,
   output logic                  lcl_timeout,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   input  logic [1:0]            m_axi_bresp,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp
);

   if (TIMEOUT_CYC < 2 || (DATA_W != 32 && DATA_W != 64)) begin : g_bad_param
      $error("axilite_mmio_bridge: illegal DATA_W or TIMEOUT_CYC");
   end

   state_e              state;
   logic                cmp_wr, cmp_rd;
   logic [1:0]          cmp_resp;
   logic [DATA_W-1:0]   cmp_rdata;

   assign lcl_busy     = (state != ST_IDLE);
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;

`ifdef AXILITE_MMIO_BRIDGE_TIMEOUT_EN
   state_e state_q;
   logic   cmp_to;
   logic   tmo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state;
   end

   axilite_mmio_bridge_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state != state_q),
      .en      (lcl_busy),
      .expired (tmo)
   );
`else
   assign lcl_timeout = 1'b0;
`endif

   // Completion is staged through cmp_* so ack/dv land one cycle after IDLE is re-entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_araddr  <= '0;
         lcl_drop      <= 1'b0;
         lcl_ack       <= 1'b0;
         lcl_dv        <= 1'b0;
         lcl_rdata     <= '0;
         lcl_resp      <= RESP_OKAY;
         cmp_wr        <= 1'b0;
         cmp_rd        <= 1'b0;
         cmp_resp      <= RESP_OKAY;
         cmp_rdata     <= '0;
`ifdef AXILITE_MMIO_BRIDGE_TIMEOUT_EN
         cmp_to        <= 1'b0;
         lcl_timeout   <= 1'b0;
`endif
      end else begin
         lcl_ack  <= cmp_wr;
         lcl_dv   <= cmp_rd;
         if (cmp_wr || cmp_rd) lcl_resp  <= cmp_resp;
         if (cmp_rd)           lcl_rdata <= cmp_rdata;
         cmp_wr   <= 1'b0;
         cmp_rd   <= 1'b0;
         lcl_drop <= lcl_busy && (lcl_wr || lcl_rd);
`ifdef AXILITE_MMIO_BRIDGE_TIMEOUT_EN
         lcl_timeout <= cmp_to;
         cmp_to      <= 1'b0;
         if (tmo) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            state         <= ST_IDLE;
            cmp_to        <= 1'b1;
            cmp_resp      <= RESP_DECERR;
            cmp_rdata     <= TIMEOUT_RDATA[DATA_W-1:0];
            cmp_wr        <= (state == ST_WR_REQ) || (state == ST_WR_RESP);
            cmp_rd        <= (state == ST_RD_REQ) || (state == ST_RD_DATA);
         end else
`endif
         unique case (state)
            ST_IDLE: begin
               if (lcl_wr) begin
                  state         <= ST_WR_REQ;
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  m_axi_awaddr  <= lcl_addr;
                  m_axi_wdata   <= lcl_wdata;
                  m_axi_wstrb   <= lcl_wstrb;
                  lcl_drop      <= lcl_rd;
               end else if (lcl_rd) begin
                  state         <= ST_RD_REQ;
                  m_axi_arvalid <= 1'b1;
                  m_axi_araddr  <= lcl_addr;
               end
            end
            ST_WR_REQ: begin
               if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
               if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                  state        <= ST_WR_RESP;
                  m_axi_bready <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  state        <= ST_IDLE;
                  cmp_wr       <= 1'b1;
                  cmp_resp     <= m_axi_bresp;
               end
            end
            ST_RD_REQ: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  state        <= ST_IDLE;
                  cmp_rd       <= 1'b1;
                  cmp_resp     <= m_axi_rresp;
                  cmp_rdata    <= m_axi_rdata;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axilite_mmio_bridge.sv
// Directed self-checking bench for axilite_mmio_bridge with a hand-driven AXI-Lite slave.
module tb_axilite_mmio_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          lcl_wr, lcl_rd;
   logic [AW-1:0] lcl_addr;
   logic [DW-1:0] lcl_wdata;
   logic [SW-1:0] lcl_wstrb;
   logic          lcl_busy, lcl_drop, lcl_ack, lcl_dv, lcl_timeout;
   logic [DW-1:0] lcl_rdata;
   logic [1:0]    lcl_resp;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   int checks = 0;
   int errors = 0;
   int n_ack = 0, n_dv = 0, n_drop = 0, n_bhs = 0, n_arv = 0;
   int d0, a0, v0;

   always #5 clk = ~clk;

   axilite_mmio_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .lcl_wr(lcl_wr), .lcl_rd(lcl_rd), .lcl_addr(lcl_addr),
      .lcl_wdata(lcl_wdata), .lcl_wstrb(lcl_wstrb),
      .lcl_busy(lcl_busy), .lcl_drop(lcl_drop), .lcl_ack(lcl_ack), .lcl_dv(lcl_dv),
      .lcl_rdata(lcl_rdata), .lcl_resp(lcl_resp), .lcl_timeout(lcl_timeout),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
   );

   // Event counters sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (lcl_ack)          n_ack++;
      if (lcl_dv)           n_dv++;
      if (lcl_drop)         n_drop++;
      if (bvalid && bready) n_bhs++;
      if (arvalid)          n_arv++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      lcl_wr = 0; lcl_rd = 0; lcl_addr = '0; lcl_wdata = '0; lcl_wstrb = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = '0; rresp = 0;

      #12;
      chk("rst_busy", lcl_busy, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_rready", rready, 0);
      chk("rst_ack_dv_drop_to", {lcl_ack, lcl_dv, lcl_drop, lcl_timeout}, 0);
      chk("rst_rdata", lcl_rdata, 0);
      chk("rst_resp", lcl_resp, 0);
      chk("rst_prot", {awprot, arprot}, 0);
      @(posedge clk); #1 rst_n = 1;
      tick;

      // Zero-wait write
      lcl_wr = 1; lcl_addr = 32'h10; lcl_wdata = 32'hA5A5_0001; lcl_wstrb = 4'hF;
      awready = 1; wready = 1;
      tick; lcl_wr = 0;
      chk("w1_c1_valids", {awvalid, wvalid}, 2'b11);
      chk("w1_c1_busy", lcl_busy, 1);
      chk("w1_awaddr", awaddr, 32'h10);
      chk("w1_wdata", wdata, 32'hA5A5_0001);
      chk("w1_wstrb", wstrb, 4'hF);
      tick;
      chk("w1_c2_valids", {awvalid, wvalid}, 2'b00);
      chk("w1_c2_bready", bready, 1);
      bvalid = 1; bresp = 2'b00;
      tick; bvalid = 0;
      chk("w1_c3_bready", bready, 0);
      chk("w1_c3_busy", lcl_busy, 0);
      chk("w1_c3_ack", lcl_ack, 0);
      tick;
      chk("w1_c4_ack", lcl_ack, 1);
      chk("w1_c4_resp", lcl_resp, 2'b00);
      tick;
      chk("w1_c5_ack", lcl_ack, 0);

      // Write with W accepted three cycles before AW
      awready = 0; wready = 1;
      lcl_wr = 1; lcl_addr = 32'h14; lcl_wdata = 32'h1234_5678; lcl_wstrb = 4'h3;
      tick; lcl_wr = 0;
      chk("w2_c1_valids", {awvalid, wvalid}, 2'b11);
      tick;
      chk("w2_c2_valids", {awvalid, wvalid}, 2'b10);
      chk("w2_c2_bready", bready, 0);
      tick;
      chk("w2_c3_awvalid", awvalid, 1);
      tick;
      chk("w2_c4_awvalid", awvalid, 1);
      chk("w2_c4_awaddr", awaddr, 32'h14);
      awready = 1;
      tick; awready = 0;
      chk("w2_c5_awvalid", awvalid, 0);
      chk("w2_c5_bready", bready, 1);
      bvalid = 1; bresp = 2'b10;
      tick; bvalid = 0;
      chk("w2_c6_bready", bready, 0);
      tick;
      chk("w2_c7_ack", lcl_ack, 1);
      chk("w2_c7_resp", lcl_resp, 2'b10);
      tick; tick;
      chk("w2_ack_count", n_ack, 2);
      chk("w2_b_count", n_bhs, 2);

      // Read with five wait cycles and SLVERR
      arready = 1;
      lcl_rd = 1; lcl_addr = 32'h20;
      tick; lcl_rd = 0;
      chk("r1_c1_arvalid", arvalid, 1);
      chk("r1_araddr", araddr, 32'h20);
      tick; arready = 0;
      chk("r1_c2_arvalid", arvalid, 0);
      chk("r1_c2_rready", rready, 1);
      repeat (5) tick;
      chk("r1_wait_rready", rready, 1);
      chk("r1_wait_dv", lcl_dv, 0);
      chk("r1_rdata_before", lcl_rdata, 0);
      rvalid = 1; rdata = 32'hDEAD_0042; rresp = 2'b10;
      tick; rvalid = 0; rdata = '0;
      chk("r1_c8_rready", rready, 0);
      chk("r1_c8_busy", lcl_busy, 0);
      tick;
      chk("r1_dv", lcl_dv, 1);
      chk("r1_rdata", lcl_rdata, 32'hDEAD_0042);
      chk("r1_resp", lcl_resp, 2'b10);
      tick;
      chk("r1_dv_off", lcl_dv, 0);
      chk("r1_rdata_hold", lcl_rdata, 32'hDEAD_0042);
      chk("r1_dv_count", n_dv, 1);

      // Simultaneous wr+rd, then rd while busy
      d0 = n_drop; a0 = n_arv;
      awready = 1; wready = 1;
      lcl_wr = 1; lcl_rd = 1; lcl_addr = 32'h30; lcl_wdata = 32'h0000_CAFE; lcl_wstrb = 4'h1;
      tick; lcl_wr = 0;
      chk("c_c1_drop", lcl_drop, 1);
      chk("c_c1_awvalid", awvalid, 1);
      chk("c_c1_arvalid", arvalid, 0);
      tick; lcl_rd = 0;
      chk("c_c2_drop", lcl_drop, 1);
      chk("c_c2_bready", bready, 1);
      bvalid = 1; bresp = 2'b00;
      tick; bvalid = 0;
      chk("c_c3_drop", lcl_drop, 0);
      tick;
      chk("c_c4_ack", lcl_ack, 1);
      chk("c_drop_count", n_drop - d0, 2);
      chk("c_no_arvalid", n_arv - a0, 0);

      // New read accepted in the ack cycle, then reset while arvalid is high
      arready = 0;
      lcl_rd = 1; lcl_addr = 32'h40;
      tick; lcl_rd = 0;
      chk("b2b_arvalid", arvalid, 1);
      chk("b2b_busy", lcl_busy, 1);
      v0 = n_dv;
      #2 rst_n = 0;
      #1;
      chk("rst_mid_arvalid", arvalid, 0);
      chk("rst_mid_busy", lcl_busy, 0);
      chk("rst_mid_rready", rready, 0);
      tick; tick;
      rst_n = 1;
      arready = 1; rvalid = 1; rdata = 32'h1111_2222;
      repeat (6) tick;
      rvalid = 0; arready = 0;
      chk("rst_mid_no_dv", n_dv - v0, 0);
      chk("rst_mid_arvalid_after", arvalid, 0);
      chk("rst_mid_rdata", lcl_rdata, 0);

`ifdef AXILITE_MMIO_BRIDGE_TIMEOUT_EN
      // Slave never answers B: abort after 16 cycles in WR_RESP
      awready = 1; wready = 1; bvalid = 0;
      lcl_wr = 1; lcl_addr = 32'h50; lcl_wdata = 32'h5; lcl_wstrb = 4'hF;
      tick; lcl_wr = 0;
      tick;
      chk("to_c2_bready", bready, 1);
      repeat (15) tick;
      chk("to_c17_bready", bready, 1);
      chk("to_c17_busy", lcl_busy, 1);
      tick;
      chk("to_c18_bready", bready, 0);
      chk("to_c18_busy", lcl_busy, 0);
      chk("to_c18_timeout", lcl_timeout, 0);
      bvalid = 1;
      tick; bvalid = 0;
      chk("to_c19_timeout", lcl_timeout, 1);
      chk("to_c19_ack", lcl_ack, 1);
      chk("to_c19_resp", lcl_resp, 2'b11);
      chk("to_late_b_bready", bready, 0);
      arready = 1;
      lcl_rd = 1; lcl_addr = 32'h60;
      tick; lcl_rd = 0;
      tick; arready = 0;
      rvalid = 1; rdata = 32'h0000_600D; rresp = 2'b00;
      tick; rvalid = 0;
      tick;
      chk("to_rd_dv", lcl_dv, 1);
      chk("to_rd_rdata", lcl_rdata, 32'h0000_600D);
      chk("to_rd_resp", lcl_resp, 2'b00);
      chk("to_rd_timeout", lcl_timeout, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
